// File: rtl/register_bank_param.sv
// Parametrised ID-stage register file: NUM_RD registered read ports, one write port,
// optional write-to-read bypass and hard-wired zero entry, cleared by a post-reset sweep.
module register_bank_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_RD*ADDR_W-1:0]          read_register,
    input  logic [ADDR_W-1:0]                 write_register,
    input  logic [DATA_W-1:0]                 write_data,
    input  logic                              Reg_write,
    output logic [NUM_RD*DATA_W-1:0]          bus,
    output logic                              ready,
    output logic [(2**ADDR_W)*DATA_W-1:0]     registros
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   clr_idx_reg;
    logic                ready_reg;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                wr_en;

    // A write only takes effect in RUN and never lands on the zero entry when it is hard-wired.
    assign wr_en = (state_reg == RUN) && Reg_write &&
                   !((ZERO_REG != 0) && (write_register == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= INIT;
            clr_idx_reg <= '0;
            ready_reg   <= 1'b0;
        end else if (state_reg == INIT) begin
            clr_idx_reg <= clr_idx_reg + 1'b1;
            if (clr_idx_reg == ADDR_W'(DEPTH - 1)) begin
                state_reg <= RUN;
                ready_reg <= 1'b1;
            end
        end
    end

    // The array itself has no reset so it can map onto RAM; the sweep clears it instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_reg == INIT)
                mem[clr_idx_reg] <= '0;
            else if (wr_en)
                mem[write_register] <= write_data;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] rd_addr;
            logic [DATA_W-1:0] bus_reg;

            assign rd_addr = read_register[gi*ADDR_W +: ADDR_W];

            always_ff @(posedge clk) begin
                if (rst || state_reg != RUN)
                    bus_reg <= '0;
                else if ((ZERO_REG != 0) && (rd_addr == '0))
                    bus_reg <= '0;
                else if ((BYPASS != 0) && wr_en && (write_register == rd_addr))
                    bus_reg <= write_data;
                else
                    bus_reg <= mem[rd_addr];
            end

            assign bus[gi*DATA_W +: DATA_W] = bus_reg;
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dump
            assign registros[gi*DATA_W +: DATA_W] = mem[gi];
        end
    endgenerate

    assign ready = ready_reg;

endmodule

// File: tb/tb_register_bank_param.sv
// Directed bench: default instance (bypass, zero reg, 2 ports) and a 3-port instance
// without bypass or zero reg share clock, reset and write port.
module tb_register_bank_param;

    logic          clk = 1'b0;
    logic          rst;
    logic [9:0]    rra;
    logic [14:0]   rrb;
    logic [4:0]    write_register;
    logic [31:0]   write_data;
    logic          Reg_write;
    logic [63:0]   bus_a;
    logic [95:0]   bus_b;
    logic          ready_a, ready_b;
    logic [1023:0] registros_a, registros_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    register_bank_param dut_a (
        .clk(clk), .rst(rst), .read_register(rra), .write_register(write_register),
        .write_data(write_data), .Reg_write(Reg_write), .bus(bus_a), .ready(ready_a),
        .registros(registros_a)
    );

    register_bank_param #(.NUM_RD(3), .BYPASS(0), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .read_register(rrb), .write_register(write_register),
        .write_data(write_data), .Reg_write(Reg_write), .bus(bus_b), .ready(ready_b),
        .registros(registros_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        write_register = addr;
        write_data     = data;
        Reg_write      = 1'b1;
        tick;
        Reg_write      = 1'b0;
        $display("write r%0d = %h", addr, data);
    endtask

    initial begin
        rst = 1'b1; Reg_write = 1'b0; write_register = '0; write_data = '0;
        rra = '0; rrb = '0;

        // Reset and clear sweep
        tick;
        rst = 1'b0;
        check("rst_ready", ready_a, 1'b0);
        check("rst_bus", bus_a, 64'h0);
        rra = {5'd5, 5'd5};
        for (int n = 1; n <= 31; n++) begin
            tick;
            check($sformatf("init_ready_e%0d", n), ready_a, 1'b0);
        end
        check("init_bus_hold", bus_a, 64'h0);
        tick;
        check("ready_e32_a", ready_a, 1'b1);
        check("ready_e32_b", ready_b, 1'b1);
        check("sweep_zero_a", registros_a, '0);
        check("sweep_zero_b", registros_b, '0);
        $display("sweep done, ready_a=%0b ready_b=%0b", ready_a, ready_b);

        // Write then read with latency 1
        wr(5'd5, 32'hDEADBEEF);
        check("dump_r5", registros_a[5*32 +: 32], 32'hDEADBEEF);
        rra = {5'd0, 5'd5};
        tick;
        check("read_r5", bus_a[31:0], 32'hDEADBEEF);
        $display("read r5 -> %h", bus_a[31:0]);

        // Same-cycle write/read: forwarded on dut_a, pre-write value on dut_b
        rra = {5'd7, 5'd0};
        rrb = {5'd0, 5'd7, 5'd0};
        wr(5'd7, 32'h12345678);
        check("bypass_on", bus_a[63:32], 32'h12345678);
        check("bypass_off", bus_b[63:32], 32'h0);
        tick;
        check("nobypass_later", bus_b[63:32], 32'h12345678);
        $display("bypass r7 a=%h b=%h", bus_a[63:32], bus_b[63:32]);

        // Zero register: write to r0 ignored on dut_a, stored on dut_b
        rra = {5'd0, 5'd0};
        rrb = '0;
        wr(5'd0, 32'hFFFFFFFF);
        check("zero_bypass_a", bus_a, 64'h0);
        check("r0_prewrite_b", bus_b[31:0], 32'h0);
        tick;
        check("zero_read_a", bus_a, 64'h0);
        check("zero_dump_a", registros_a[31:0], 32'h0);
        check("r0_written_b", bus_b[31:0], 32'hFFFFFFFF);
        $display("r0 read a=%h b=%h", bus_a[31:0], bus_b[31:0]);

        // Two ports on the same entry
        rra = {5'd5, 5'd5};
        tick;
        check("same_entry", bus_a, {32'hDEADBEEF, 32'hDEADBEEF});

        // Three ports in parallel
        wr(5'd1, 32'h00000001);
        wr(5'd2, 32'h00000002);
        wr(5'd31, 32'hCAFEF00D);
        rrb = {5'd31, 5'd2, 5'd1};
        tick;
        check("three_ports", bus_b, {32'hCAFEF00D, 32'h00000002, 32'h00000001});
        $display("3-port read -> %h", bus_b);

        // Mid-run reset, write attempted during sweep, reset again mid-sweep
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rerst_ready", ready_a, 1'b0);
        check("rerst_bus", bus_a, 64'h0);
        rra = {5'd3, 5'd3};
        for (int n = 1; n <= 4; n++) tick;
        wr(5'd3, 32'hA5A5A5A5);
        check("init_write_ignored", registros_a[3*32 +: 32], 32'h0);
        check("init_bus_zero", bus_a, 64'h0);
        for (int n = 6; n <= 9; n++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("second_rst_ready", ready_a, 1'b0);
        for (int n = 1; n <= 31; n++) begin
            tick;
            check($sformatf("resweep_ready_e%0d", n), ready_a, 1'b0);
        end
        tick;
        check("resweep_ready_e32", ready_a, 1'b1);
        check("resweep_all_zero", registros_a, '0);
        rra = {5'd0, 5'd3};
        tick;
        check("r3_reads_zero", bus_a[31:0], 32'h0);
        $display("after resweep r3 -> %h", bus_a[31:0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
